// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes used by the ALU decode and the
// multi-cycle multiply/divide sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_OP_MUL = 4'd9;
  localparam logic [3:0] ALU_OP_DIV = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of either a shift-add multiply or a restoring divide.
// Accumulator layout: {high half, low half}; low half holds multiplier / quotient.
module muldiv_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    sum       = '0;
    rem_shift = '0;
    diff      = '0;
    acc_next  = '0;
    if (is_div) begin
      // Shift {rem, dividend} left one bit and try subtracting the divisor.
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      if (rem_shift >= {1'b0, operand}) begin
        diff     = rem_shift - {1'b0, operand};
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      // The carry out of the add shifts into the product's top bit.
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV engine for the execute stage.
// Optional `MULDIV_REMAINDER_EN`: drive the DIV remainder on resultUpperWord.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] Rdst,
  input  logic [WIDTH-1:0] Rsrc,
  input  logic             ZF_in,
  input  logic             NF_in,
  input  logic             CF_in,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] resultLowerWord,
  output logic [WIDTH-1:0] resultUpperWord,
  output logic             ZF_out,
  output logic             NF_out,
  output logic             CF_out
);

  muldiv_state_t     state, state_next;
  logic [4:0]        cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]  operand_q;
  logic              op_div_q;
  logic              cf_q;
  logic              op_valid, op_is_div;
  logic              accept, div_zero, finish;

  assign op_is_div = (ALU_OP == ALU_OP_DIV);
  assign op_valid  = (ALU_OP == ALU_OP_MUL) || op_is_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand_q),
    .is_div   (op_div_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    div_zero   = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && op_valid) begin
          stall  = 1'b1;
          accept = 1'b1;
          if (op_is_div && (Rsrc == '0)) begin
            div_zero   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = ~flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      operand_q <= '0;
      op_div_q  <= 1'b0;
      cf_q      <= 1'b0;
    end else if (accept) begin
      cnt       <= 5'(WIDTH - 1);
      acc       <= {{WIDTH{1'b0}}, (op_is_div ? Rdst : Rsrc)};
      operand_q <= op_is_div ? Rsrc : Rdst;
      op_div_q  <= op_is_div;
      cf_q      <= CF_in;
    end else if (state == CALC) begin
      acc <= acc_next;
      cnt <= cnt - 5'd1;
    end
  end

  // Results load on the edge entering DONE, so they are visible while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultLowerWord <= '0;
      resultUpperWord <= '0;
      ZF_out          <= 1'b0;
      NF_out          <= 1'b0;
      CF_out          <= 1'b0;
    end else if (div_zero) begin
      resultLowerWord <= '1;
`ifdef MULDIV_REMAINDER_EN
      resultUpperWord <= Rdst;
`else
      resultUpperWord <= '0;
`endif
      ZF_out          <= 1'b0;
      NF_out          <= 1'b1;
      CF_out          <= 1'b1;
    end else if (finish) begin
      resultLowerWord <= acc_next[WIDTH-1:0];
      CF_out          <= cf_q;
      if (op_div_q) begin
`ifdef MULDIV_REMAINDER_EN
        resultUpperWord <= acc_next[2*WIDTH-1:WIDTH];
`else
        resultUpperWord <= '0;
`endif
        NF_out <= acc_next[WIDTH-1];
        ZF_out <= (acc_next[WIDTH-1:0] == '0);
      end else begin
        resultUpperWord <= acc_next[2*WIDTH-1:WIDTH];
        NF_out          <= acc_next[2*WIDTH-1];
        ZF_out          <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed MUL/DIV vectors, flush and reset aborts.
module tb_muldiv_sequencer;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        z;
    logic        n;
    logic        c;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ALU_OP = 4'd0;
  logic [15:0] Rdst = '0;
  logic [15:0] Rsrc = '0;
  logic        ZF_in = 1'b0;
  logic        NF_in = 1'b0;
  logic        CF_in = 1'b0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [15:0] resultLowerWord, resultUpperWord;
  logic        ZF_out, NF_out, CF_out;

  int total = 0;
  int bad = 0;
  int pushed = 0;
  int dones = 0;
  res_t sb[$];
  res_t last_res;

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ALU_OP          (ALU_OP),
    .Rdst            (Rdst),
    .Rsrc            (Rsrc),
    .ZF_in           (ZF_in),
    .NF_in           (NF_in),
    .CF_in           (CF_in),
    .flush           (flush),
    .stall           (stall),
    .done            (done),
    .resultLowerWord (resultLowerWord),
    .resultUpperWord (resultUpperWord),
    .ZF_out          (ZF_out),
    .NF_out          (NF_out),
    .CF_out          (CF_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_outputs(string tag, res_t e);
    chk({tag, "_lo"}, 32'(resultLowerWord), 32'(e.lo));
    chk({tag, "_hi"}, 32'(resultUpperWord), 32'(e.hi));
    chk({tag, "_zf"}, 32'(ZF_out), 32'(e.z));
    chk({tag, "_nf"}, 32'(NF_out), 32'(e.n));
    chk({tag, "_cf"}, 32'(CF_out), 32'(e.c));
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        res_t e;
        e = sb.pop_front();
        chk_outputs("result", e);
        last_res = e;
      end
    end
  end

  task automatic run_op(input logic is_div, input logic [15:0] a, input logic [15:0] b,
                        input logic cf, input int lat, input res_t e, input logic poke_busy);
    int cyc;
    @(posedge clk); #1;
    start  = 1'b1;
    ALU_OP = is_div ? 4'd10 : 4'd9;
    Rdst   = a;
    Rsrc   = b;
    CF_in  = cf;
    sb.push_back(e);
    pushed++;
    @(negedge clk);
    chk("stall_c0", 32'(stall), 32'd1);
    chk("done_c0", 32'(done), 32'd0);
    cyc = 1;
    @(posedge clk); #1;
    start = 1'b0;
    CF_in = ~cf;
    forever begin
      @(negedge clk);
      if (done || cyc > 40) break;
      chk("stall_calc", 32'(stall), 32'd1);
      cyc++;
      @(posedge clk); #1;
      start = poke_busy && (cyc == 3);
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    chk("stall_done", 32'(stall), 32'd0);
  endtask

  task automatic idle_no_done(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_done", 32'(done), 32'd0);
    end
  endtask

  res_t e;

  initial begin
    last_res = '{lo: 16'h0, hi: 16'h0, z: 1'b0, n: 1'b0, c: 1'b0};
    #12;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_outputs("rst", last_res);
    rst_n = 1'b1;

    // Illegal op code is ignored.
    @(posedge clk); #1;
    start = 1'b1; ALU_OP = 4'd3;
    @(negedge clk);
    chk("badop_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    idle_no_done(3);

    e = '{lo: 16'h2340, hi: 16'h0001, z: 1'b0, n: 1'b0, c: 1'b1};
    run_op(1'b0, 16'h1234, 16'h0010, 1'b1, 17, e, 1'b0);
    e = '{lo: 16'h0001, hi: 16'hFFFE, z: 1'b0, n: 1'b1, c: 1'b0};
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 17, e, 1'b0);
    e = '{lo: 16'h0000, hi: 16'h0000, z: 1'b1, n: 1'b0, c: 1'b1};
    run_op(1'b0, 16'h0000, 16'h5A5A, 1'b1, 17, e, 1'b0);
`ifdef MULDIV_REMAINDER_EN
    e = '{lo: 16'h000E, hi: 16'h0002, z: 1'b0, n: 1'b0, c: 1'b0};
`else
    e = '{lo: 16'h000E, hi: 16'h0000, z: 1'b0, n: 1'b0, c: 1'b0};
`endif
    run_op(1'b1, 16'd100, 16'd7, 1'b0, 17, e, 1'b1);
`ifdef MULDIV_REMAINDER_EN
    e = '{lo: 16'h0000, hi: 16'h0005, z: 1'b1, n: 1'b0, c: 1'b1};
`else
    e = '{lo: 16'h0000, hi: 16'h0000, z: 1'b1, n: 1'b0, c: 1'b1};
`endif
    run_op(1'b1, 16'd5, 16'd9, 1'b1, 17, e, 1'b0);
`ifdef MULDIV_REMAINDER_EN
    e = '{lo: 16'hFFFF, hi: 16'h1234, z: 1'b0, n: 1'b1, c: 1'b1};
`else
    e = '{lo: 16'hFFFF, hi: 16'h0000, z: 1'b0, n: 1'b1, c: 1'b1};
`endif
    run_op(1'b1, 16'h1234, 16'h0000, 1'b0, 1, e, 1'b0);
    idle_no_done(2);

    // Flush in cycle 8 of a MUL: back to IDLE, no done, outputs held.
    @(posedge clk); #1;
    start = 1'b1; ALU_OP = 4'd9; Rdst = 16'h00FF; Rsrc = 16'h0101; CF_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    chk_outputs("flush_hold", last_res);
    idle_no_done(20);
    e = '{lo: 16'hFFFF, hi: 16'h0000, z: 1'b0, n: 1'b0, c: 1'b0};
    run_op(1'b0, 16'h00FF, 16'h0101, 1'b0, 17, e, 1'b0);

    // Reset in cycle 5 of a DIV: everything back to reset values at once.
    @(posedge clk); #1;
    start = 1'b1; ALU_OP = 4'd10; Rdst = 16'd100; Rsrc = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    last_res = '{lo: 16'h0, hi: 16'h0, z: 1'b0, n: 1'b0, c: 1'b0};
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk_outputs("arst", last_res);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_no_done(20);
    e = '{lo: 16'h0010, hi: 16'h0000, z: 1'b0, n: 1'b0, c: 1'b1};
    run_op(1'b1, 16'h0100, 16'h0010, 1'b1, 17, e, 1'b0);
    idle_no_done(3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
